// File: rtl/stress_pkg.sv
// ----------------------------------------------------------------------------
// stress_pkg
// Shared definitions for the stress averager and the downstream comparator.
//   STRESS_DW : default sample / average width
//   stress_t  : one stress sample or averaged stress value
//   state_t   : averager window state (FILL while priming, RUN once full)
// ----------------------------------------------------------------------------
package stress_pkg;

  localparam int STRESS_DW = 8;

  typedef logic [STRESS_DW-1:0] stress_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : stress_pkg

// File: rtl/stress_ring.sv
// ----------------------------------------------------------------------------
// stress_ring
// 2**LOG2_WIN x DW register file holding the sample window.
// Ports:
//   clk     in   system clock, rising edge
//   i_we    in   write enable
//   i_addr  in   shared read/write address
//   i_wdata in   data written at i_addr
//   o_rdata out  asynchronous read of i_addr (returns the old value in the
//                cycle it is being overwritten, i.e. read-before-write)
// The contents carry no reset: the averager never reads a slot before
// writing it in the current window.
// ----------------------------------------------------------------------------
module stress_ring #(
  parameter int DW       = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [LOG2_WIN-1:0] i_addr,
  input  logic [DW-1:0]       i_wdata,
  output logic [DW-1:0]       o_rdata
);

  localparam int DEPTH = 2 ** LOG2_WIN;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule : stress_ring

// File: rtl/stress_averager.sv
// ----------------------------------------------------------------------------
// stress_averager
// Moving average of raw stress samples over a window of 2**LOG2_WIN samples.
// The average feeds the "a" input of the rocking-threshold comparator.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   sample_in    in   raw stress sample
//   sample_valid in   sample_in is accepted this cycle
//   clear        in   synchronous window restart (wins over sample_valid)
//   stress_out   out  registered windowed average (sum >> LOG2_WIN)
//   stress_valid out  high once the window has been filled
//   stress_peak  out  peak-hold of stress_out while valid
// Build option: define STRESS_PEAK_EN to build the peak-hold register;
// otherwise stress_peak is tied to zero.
// ----------------------------------------------------------------------------
module stress_averager
  import stress_pkg::*;
#(
  parameter int DW       = STRESS_DW,
  parameter int LOG2_WIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          clear,
  output logic [DW-1:0] stress_out,
  output logic          stress_valid,
  output logic [DW-1:0] stress_peak
);

  localparam int SW = DW + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST_SLOT = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic [LOG2_WIN-1:0] r_wr_ptr;
  logic [LOG2_WIN-1:0] r_fill_cnt;
  logic [SW-1:0]       r_sum;
  logic [DW-1:0]       r_out;
  logic [DW-1:0]       w_ring_rd;
  logic [SW-1:0]       w_oldest;
  logic [SW-1:0]       w_next_sum;
  logic [DW-1:0]       w_next_avg;
  logic                w_accept;

  assign w_accept = sample_valid && !clear;

  stress_ring #(
    .DW       (DW),
    .LOG2_WIN (LOG2_WIN)
  ) u_ring (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_wr_ptr),
    .i_wdata (sample_in),
    .o_rdata (w_ring_rd)
  );

  // While filling, ring slots hold stale data from an earlier window, so the
  // outgoing sample is forced to zero until every slot has been rewritten.
  assign w_oldest   = (r_state == RUN) ? {{LOG2_WIN{1'b0}}, w_ring_rd} : '0;
  assign w_next_sum = r_sum + {{LOG2_WIN{1'b0}}, sample_in} - w_oldest;
  assign w_next_avg = w_next_sum[SW-1:LOG2_WIN];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = FILL;
    end else if (w_accept && (r_state == FILL) && (r_fill_cnt == LAST_SLOT)) begin
      w_state_next = RUN;
    end
  end

  // FSM: outputs (valid follows the registered state, so it rises on the
  // same edge that accepts the last sample of the first window)
  always_comb begin
    stress_valid = (r_state == RUN);
    stress_out   = r_out;
  end

  // Datapath: pointer, fill counter, accumulator and averaged output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_sum      <= '0;
      r_out      <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_sum      <= '0;
      r_out      <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == FILL) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      r_sum <= w_next_sum;
      r_out <= w_next_avg;
    end
  end

`ifdef STRESS_PEAK_EN
  logic [DW-1:0] r_peak;

  // The accept that completes the first window already counts as RUN, so
  // the first valid average is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (clear) begin
      r_peak <= '0;
    end else if (w_accept && (w_state_next == RUN) && (w_next_avg > r_peak)) begin
      r_peak <= w_next_avg;
    end
  end

  assign stress_peak = r_peak;
`else
  assign stress_peak = '0;
`endif

endmodule : stress_averager

// File: tb/tb_stress_averager.sv
module tb_stress_averager;
  import stress_pkg::*;

  localparam int WIN = 8;
`ifdef STRESS_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  stress_t sample_in = '0;
  logic    sample_valid = 1'b0;
  logic    clear = 1'b0;
  stress_t stress_out;
  logic    stress_valid;
  stress_t stress_peak;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the window is the list of the most recent accepted
  // samples since the last clear/reset; the average is their sum over WIN.
  int win_q[$];
  int m_acc   = 0;
  int m_out   = 0;
  int m_valid = 0;
  int m_peak  = 0;

  stress_averager dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .stress_out   (stress_out),
    .stress_valid (stress_valid),
    .stress_peak  (stress_peak)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    win_q.delete();
    m_acc = 0; m_out = 0; m_valid = 0; m_peak = 0;
  endfunction

  function automatic void model_accept(input int s);
    int total;
    win_q.push_back(s);
    if (win_q.size() > WIN) void'(win_q.pop_front());
    m_acc++;
    total = 0;
    foreach (win_q[k]) total += win_q[k];
    m_out   = total / WIN;
    m_valid = (m_acc >= WIN) ? 1 : 0;
    if (m_valid != 0 && m_out > m_peak) m_peak = m_out;
  endfunction

  function automatic int exp_peak();
    return PEAK_EN ? m_peak : 0;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic apply(input bit v, input int s, input bit c);
    @(negedge clk);
    sample_valid = v;
    sample_in    = stress_t'(s);
    clear        = c;
    @(posedge clk);
    #1;
    if (c) model_reset();
    else if (v) model_accept(s);
    sample_valid = 1'b0;
    clear        = 1'b0;
    $display("txn v=%0d c=%0d s=%0d -> out=%0d valid=%0d peak=%0d", v, c, s,
             stress_out, stress_valid, stress_peak);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    model_reset();
    n_vec++;
    if (stress_out !== 8'd0 || stress_valid !== 1'b0 || stress_peak !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: out=%0d valid=%0d peak=%0d, required 0/0/0",
               stress_out, stress_valid, stress_peak);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < WIN; i++) begin
      apply(1'b1, 80, 1'b0);
      n_vec++;
      if (stress_valid !== 1'(m_valid) || stress_out !== 8'(m_out)) begin
        n_bad++;
        $display("FAIL fill[%0d]: out=%0d valid=%0d, required %0d/%0d",
                 i, stress_out, stress_valid, m_out, m_valid);
      end
    end
    n_vec++;
    if (stress_out !== 8'd80 || stress_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_full: out=%0d valid=%0d, required 80/1", stress_out, stress_valid);
    end
  endtask

  task automatic test_step();
    apply(1'b1, 160, 1'b0);
    n_vec++;
    if (stress_out !== 8'd90 || stress_out !== 8'(m_out)) begin
      n_bad++;
      $display("FAIL step: out=%0d, required 90", stress_out);
    end
  endtask

  task automatic test_saturate();
    apply(1'b0, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 255, 1'b0);
      n_vec++;
      if (stress_out !== 8'(m_out) || stress_valid !== 1'(m_valid)) begin
        n_bad++;
        $display("FAIL saturate[%0d]: out=%0d valid=%0d, required %0d/%0d",
                 i, stress_out, stress_valid, m_out, m_valid);
      end
    end
    n_vec++;
    if (stress_out !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate_end: out=%0d, required 255", stress_out);
    end
  endtask

  task automatic test_clear_override();
    apply(1'b1, 200, 1'b1);
    n_vec++;
    if (stress_out !== 8'd0 || stress_valid !== 1'b0 || stress_peak !== 8'd0) begin
      n_bad++;
      $display("FAIL clear_override: out=%0d valid=%0d peak=%0d, required 0/0/0",
               stress_out, stress_valid, stress_peak);
    end
    for (int i = 0; i < WIN; i++) begin
      apply(1'b1, 16 * (i + 1), 1'b0);
      n_vec++;
      if (stress_valid !== 1'(m_valid) || stress_out !== 8'(m_out)) begin
        n_bad++;
        $display("FAIL refill[%0d]: out=%0d valid=%0d, required %0d/%0d",
                 i, stress_out, stress_valid, m_out, m_valid);
      end
    end
  endtask

  task automatic test_async_rst();
    apply(1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) apply(1'b1, 250, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (stress_out !== 8'd0 || stress_valid !== 1'b0 || stress_peak !== 8'd0) begin
      n_bad++;
      $display("FAIL async_rst: out=%0d valid=%0d peak=%0d, required 0/0/0",
               stress_out, stress_valid, stress_peak);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < WIN; i++) apply(1'b1, 40, 1'b0);
    n_vec++;
    if (stress_out !== 8'd40 || stress_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst: out=%0d valid=%0d, required 40/1", stress_out, stress_valid);
    end
  endtask

  task automatic test_peak();
    apply(1'b0, 0, 1'b1);
    for (int i = 0; i < WIN; i++) apply(1'b1, 100, 1'b0);
    for (int i = 0; i < WIN; i++) begin
      apply(1'b1, 20, 1'b0);
      n_vec++;
      if (stress_peak !== 8'(exp_peak()) || stress_out !== 8'(m_out)) begin
        n_bad++;
        $display("FAIL peak[%0d]: peak=%0d out=%0d, required %0d/%0d",
                 i, stress_peak, stress_out, exp_peak(), m_out);
      end
    end
    n_vec++;
    if (stress_out !== 8'd20 || stress_peak !== (PEAK_EN ? 8'd100 : 8'd0)) begin
      n_bad++;
      $display("FAIL peak_end: out=%0d peak=%0d, required 20/%0d",
               stress_out, stress_peak, PEAK_EN ? 100 : 0);
    end
  endtask

  task automatic test_random();
    bit v, c;
    int s;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      s = $urandom_range(0, 255);
      apply(v, s, c);
      n_vec++;
      if (stress_out !== 8'(m_out) || stress_valid !== 1'(m_valid) ||
          stress_peak !== 8'(exp_peak())) begin
        n_bad++;
        $display("FAIL random[%0d]: out=%0d valid=%0d peak=%0d, required %0d/%0d/%0d",
                 i, stress_out, stress_valid, stress_peak, m_out, m_valid, exp_peak());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_step();
    test_saturate();
    test_clear_override();
    test_async_rst();
    test_peak();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_stress_averager
